cmul_ctrl_param: RTL

//  Parametrised controller for the complex-number multiplier datapath, computing (ar+j*ai)*(br+j*bi).

---
 rtl/cmul_pkg.sv | 37 +++
 rtl/cmul_pass_cnt.sv | 60 ++++++
 rtl/cmul_ctrl_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/cmul_pkg.sv
// cmul_pkg: shared types and helpers for the parametrised complex-multiply controller.
`default_nettype none

package cmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULT     = 2'd1,
    ST_COMPUTE  = 2'd2,
    ST_WAIT_RES = 2'd3
  } state_e;

  // Product slots: P0=ar*br, P1=ai*bi, P2=ar*bi, P3=ai*br
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;

  function automatic int clog2(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

  function automatic bit num_mult_ok(input int n);
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmul_pass_cnt.sv
// cmul_pass_cnt: latency counter within a pass and pass index across an operation.
`default_nettype none

module cmul_pass_cnt
  import cmul_pkg::*;
#(
  parameter int PASSES   = 2,
  parameter int MULT_LAT = 1,
  parameter int PIDX_W   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [PIDX_W-1:0] pass_idx_o,
  output logic              last_pass_o,
  output logic              pass_done_o
);

  localparam int LAT_W = idx_width(MULT_LAT);
  localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(MULT_LAT - 1);
  localparam logic [PIDX_W-1:0] PASS_MAX = PIDX_W'(PASSES - 1);

  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [PIDX_W-1:0] pass_q, pass_d;

  assign pass_done_o = (lat_q == LAT_MAX);
  assign last_pass_o = (pass_q == PASS_MAX);
  assign pass_idx_o  = pass_q;

  // Wrapping back to 0 after the final pass leaves the counter ready for a back-to-back op.
  always_comb begin
    lat_d  = lat_q;
    pass_d = pass_q;
    if (clr_i) begin
      lat_d  = '0;
      pass_d = '0;
    end else if (en_i) begin
      if (pass_done_o) begin
        lat_d  = '0;
        pass_d = last_pass_o ? '0 : pass_q + 1'b1;
      end else begin
        lat_d  = lat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_q  <= '0;
      pass_q <= '0;
    end else begin
      lat_q  <= lat_d;
      pass_q <= pass_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmul_ctrl_param.sv
// cmul_ctrl_param: sequences the four real products of a complex multiply over NUM_MULT
// multipliers, then gates the final add/sub and runs the operand/result handshakes.
`default_nettype none

module cmul_ctrl_param
  import cmul_pkg::*;
#(
  parameter  int NUM_MULT = 2,
  parameter  int MULT_LAT = 1,
  localparam int PASSES   = 4 / ((NUM_MULT > 0) ? NUM_MULT : 1),
  localparam int PIDX_W   = idx_width(PASSES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sw_rst,
  input  logic              op_val,
  output logic              op_ready,
  input  logic              conj_in,
  output logic              op_load,
  output logic [PIDX_W-1:0] pass_idx,
  output logic              prod_we,
  output logic              compute_enable,
  output logic              conj_mode,
  output logic              res_val,
  input  logic              res_ready,
  output logic              busy
);

  if (!num_mult_ok(NUM_MULT)) begin : g_bad_num_mult
    $error("cmul_ctrl_param: NUM_MULT must be 1, 2 or 4");
  end

  if (MULT_LAT < 1) begin : g_bad_mult_lat
    $error("cmul_ctrl_param: MULT_LAT must be at least 1");
  end

  state_e state_q, state_d;
  logic   conj_q;
  logic   cnt_clr;
  logic   cnt_en;
  logic   last_pass;
  logic   pass_done;

  assign busy           = (state_q != ST_IDLE);
  assign res_val        = (state_q == ST_WAIT_RES);
  // A result handshake frees the controller in the same cycle, allowing back-to-back accepts.
  assign op_ready       = ~sw_rst & ((state_q == ST_IDLE) | (res_val & res_ready));
  assign op_load        = op_val & op_ready;
  assign prod_we        = ~sw_rst & (state_q == ST_MULT) & pass_done;
  assign compute_enable = ~sw_rst & (state_q == ST_COMPUTE);
  assign conj_mode      = conj_q;

  assign cnt_clr = sw_rst | op_load;
  assign cnt_en  = (state_q == ST_MULT);

  cmul_pass_cnt #(
    .PASSES   (PASSES),
    .MULT_LAT (MULT_LAT),
    .PIDX_W   (PIDX_W)
  ) u_pass_cnt (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .pass_idx_o  (pass_idx),
    .last_pass_o (last_pass),
    .pass_done_o (pass_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (op_load) state_d = ST_MULT;
      end
      ST_MULT: begin
        if (pass_done && last_pass) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (res_ready) state_d = op_load ? ST_MULT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      conj_q  <= 1'b0;
    end else if (sw_rst) begin
      state_q <= ST_IDLE;
      conj_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (op_load) conj_q <= conj_in;
    end
  end

endmodule

`default_nettype wire
